uart_rx_frame_parser: RTL and testbench

UART_RX_FRAME_PARSER -- requirements
Module: uart_rx_frame_parser

---
 rtl/uart_rx_frame_parser.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_frame_parser.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
// Parses framed byte streams of the form SYNC, CMD, LEN, LEN x payload, CHK
// where CHK is the XOR of CMD, LEN and every payload byte. Payload bytes are
// forwarded one cycle after they arrive; completion or abort is signalled by
// a one-cycle frame_ok / frame_err strobe with a sticky abort reason.
//
// Optional feature: define UART_RX_FRAME_TIMEOUT_EN to build an inter-byte
// idle counter that aborts a partially received frame after TIMEOUT_CYCLES
// clock cycles without a byte (err_code 2'b11). Without the macro the parser
// waits indefinitely in every state.
module uart_rx_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 5500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_valid,
    output logic [7:0] pay_data,
    output logic       pay_valid,
    output logic [7:0] frame_cmd,
    output logic [7:0] frame_len,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHK     = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
`ifdef UART_RX_FRAME_TIMEOUT_EN
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;
    localparam int         IW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHECK   = 3'd4
    } state_t;

    state_t     state_q;
    logic [7:0] chk_q;
    logic [7:0] cnt_q;
    logic [7:0] pay_data_q;
    logic       pay_valid_q;
    logic [7:0] frame_cmd_q;
    logic [7:0] frame_len_q;
    logic       frame_ok_q;
    logic       frame_err_q;
    logic [1:0] err_code_q;
`ifdef UART_RX_FRAME_TIMEOUT_EN
    logic [IW-1:0] idle_q;
`endif

    // Running checksum and payload count as they would be after this byte.
    logic [7:0] chk_d;
    logic [7:0] cnt_d;
    assign chk_d = chk_q ^ rx_byte;
    assign cnt_d = cnt_q + 8'd1;

    // Frame FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            chk_q       <= 8'h00;
            cnt_q       <= 8'h00;
            pay_data_q  <= 8'h00;
            pay_valid_q <= 1'b0;
            frame_cmd_q <= 8'h00;
            frame_len_q <= 8'h00;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
`ifdef UART_RX_FRAME_TIMEOUT_EN
            idle_q      <= '0;
`endif
        end else begin
            pay_valid_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (rx_byte_valid) begin
`ifdef UART_RX_FRAME_TIMEOUT_EN
                // A byte always wins over a timeout reached in the same cycle.
                idle_q <= '0;
`endif
                case (state_q)
                    HUNT: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state_q <= CMD;
                            chk_q   <= 8'h00;
                        end
                    end
                    CMD: begin
                        frame_cmd_q <= rx_byte;
                        chk_q       <= chk_d;
                        state_q     <= LEN;
                    end
                    LEN: begin
                        frame_len_q <= rx_byte;
                        chk_q       <= chk_d;
                        cnt_q       <= 8'h00;
                        if (rx_byte == 8'h00) begin
                            state_q <= CHECK;
                        end else if (rx_byte > MAX_LEN_B) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state_q     <= HUNT;
                        end else begin
                            state_q <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        chk_q       <= chk_d;
                        pay_data_q  <= rx_byte;
                        pay_valid_q <= 1'b1;
                        cnt_q       <= cnt_d;
                        if (cnt_d == frame_len_q) begin
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (rx_byte == chk_q) begin
                            frame_ok_q <= 1'b1;
                            err_code_q <= ERR_NONE;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CHK;
                        end
                        state_q <= HUNT;
                    end
                    default: state_q <= HUNT;
                endcase
            end
`ifdef UART_RX_FRAME_TIMEOUT_EN
            else if (state_q != HUNT) begin
                // Count idle cycles inside a frame; the TIMEOUT_CYCLES-th aborts it.
                if (idle_q == IDLE_LAST) begin
                    frame_err_q <= 1'b1;
                    err_code_q  <= ERR_TIMEOUT;
                    state_q     <= HUNT;
                    idle_q      <= '0;
                end else begin
                    idle_q <= idle_q + 1'b1;
                end
            end
`endif
        end
    end

    assign pay_data  = pay_data_q;
    assign pay_valid = pay_valid_q;
    assign frame_cmd = frame_cmd_q;
    assign frame_len = frame_len_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Testbench for uart_rx_frame_parser: directed frames plus randomized traffic.
// A byte-buffer reference model queues expected strobes with the cycle they are
// due; an independent negedge monitor pops and compares them.
module tb_uart_rx_frame_parser;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int MAXL = 16;
    localparam int TO   = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_byte_valid = 1'b0;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    uart_rx_frame_parser #(
        .SYNC_BYTE     (SYNC),
        .MAX_LEN       (MAXL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .pay_data     (pay_data),
        .pay_valid    (pay_valid),
        .frame_cmd    (frame_cmd),
        .frame_len    (frame_len),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // kind: 0 payload byte, 1 frame_ok, 2 frame_err
    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [7:0] cmd;
        logic [7:0] len;
        logic [1:0] code;
        int         due;
    } ev_t;

    ev_t exp_q[$];

    // Reference model state: bytes received since the sync marker.
    bit         in_frame = 0;
    logic [7:0] fbuf[$];
    int         idle = 0;
    logic [7:0] m_cmd = 8'h00;
    logic [7:0] m_len = 8'h00;
    logic [1:0] m_err = 2'b00;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push_ev(input int kind, input logic [7:0] data, input int due);
        ev_t e;
        e.kind = kind; e.data = data; e.cmd = m_cmd; e.len = m_len;
        e.code = m_err; e.due = due;
        exp_q.push_back(e);
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] b, input int due);
        int n;
        logic [7:0] x;
        if (v) begin
            idle = 0;
            if (!in_frame) begin
                if (b == SYNC) begin
                    in_frame = 1;
                    fbuf.delete();
                end
                return;
            end
            fbuf.push_back(b);
            n = fbuf.size();
            if (n == 1) m_cmd = b;
            if (n == 2) begin
                m_len = b;
                if (int'(b) > MAXL) begin
                    m_err = 2'b10;
                    push_ev(2, 8'h00, due);
                    in_frame = 0;
                    return;
                end
            end
            if (n >= 3 && n <= int'(m_len) + 2) push_ev(0, b, due);
            if (n == int'(m_len) + 3) begin
                x = 8'h00;
                for (int i = 0; i < n - 1; i++) x = x ^ fbuf[i];
                if (x == b) begin
                    m_err = 2'b00;
                    push_ev(1, 8'h00, due);
                end else begin
                    m_err = 2'b01;
                    push_ev(2, 8'h00, due);
                end
                in_frame = 0;
            end
        end else if (in_frame) begin
`ifdef UART_RX_FRAME_TIMEOUT_EN
            idle++;
            if (idle == TO) begin
                m_err = 2'b11;
                push_ev(2, 8'h00, due);
                in_frame = 0;
                idle = 0;
            end
`endif
        end
    endfunction

    task automatic drive(input bit v, input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_byte_valid = v;
        rx_byte = v ? b : 8'h00;
        model_step(v, b, cyc + 1);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic send_list(input logic [7:0] bl[$]);
        foreach (bl[i]) send(bl[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0;
        reset = 1'b1;
        in_frame = 0; idle = 0; m_cmd = 8'h00; m_len = 8'h00; m_err = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check("rst_pay_valid", pay_valid, 0);
        check("rst_pay_data", pay_data, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_frame_cmd", frame_cmd, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected event, on time.
    always @(negedge clk) begin
        if (!reset) begin
            if (pay_valid || frame_ok || frame_err) begin
                check("strobe_exclusive", int'(pay_valid) + int'(frame_ok) + int'(frame_err), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    ev_t e;
                    int k;
                    e = exp_q.pop_front();
                    k = pay_valid ? 0 : (frame_ok ? 1 : 2);
                    check("strobe_kind", k, e.kind);
                    check("strobe_cycle", cyc, e.due);
                    check("frame_cmd", frame_cmd, e.cmd);
                    check("frame_len", frame_len, e.len);
                    if (e.kind == 0) check("pay_data", pay_data, e.data);
                    else check("err_code", err_code, e.code);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                check("missing_strobe_kind", -1, exp_q[0].kind);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bl[$];
        do_reset();

        // Directed vectors
        bl = '{8'h3C, 8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65}; send_list(bl); idles(3);
        bl = '{8'hA5, 8'h07, 8'h00, 8'h07};                     send_list(bl); idles(3);
        bl = '{8'hA5, 8'h10, 8'h01, 8'hA5, 8'h00};              send_list(bl); idles(3);
        bl = '{8'hA5, 8'h01, 8'h11};                            send_list(bl); idles(2);
        bl = '{8'hA5, 8'h07, 8'h00, 8'h07};                     send_list(bl); idles(2);
        // Maximum length frame, back-to-back
        bl = '{8'hA5, 8'h5A, 8'h10};
        begin
            logic [7:0] x;
            x = 8'h5A ^ 8'h10;
            for (int i = 0; i < MAXL; i++) begin
                bl.push_back(8'(i * 17 + 3));
                x = x ^ 8'(i * 17 + 3);
            end
            bl.push_back(x);
        end
        send_list(bl); idles(3);

        // Reset mid-frame abandons the frame silently
        bl = '{8'hA5, 8'h10, 8'h02, 8'h33}; send_list(bl); idles(2);
        do_reset();
        bl = '{8'hA5, 8'h07, 8'h00, 8'h07}; send_list(bl); idles(3);

`ifdef UART_RX_FRAME_TIMEOUT_EN
        bl = '{8'hA5, 8'h10}; send_list(bl); idles(TO); idles(3);
        bl = '{8'hA5, 8'h10}; send_list(bl); idles(TO - 1);
        bl = '{8'h00, 8'h10}; send_list(bl); idles(3);
`endif

        // Randomized frames with junk, gaps, bad lengths and bad checksums
        for (int f = 0; f < 60; f++) begin
            logic [7:0] cmd, len, x, b;
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                send(b);
            end
            cmd = 8'($urandom);
            len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(17, 255))
                                              : 8'($urandom_range(0, MAXL));
            send(SYNC); idles($urandom_range(0, 2));
            send(cmd);  idles($urandom_range(0, 2));
            send(len);  idles($urandom_range(0, 2));
            if (int'(len) <= MAXL) begin
                x = cmd ^ len;
                for (int i = 0; i < int'(len); i++) begin
                    b = 8'($urandom);
                    x = x ^ b;
                    send(b);
                    idles($urandom_range(0, 1));
                end
                if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
                send(x);
            end
            idles($urandom_range(0, 3));
        end

        idles(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
